fixed_to_float_seq: RTL and testbench

//  Multi-cycle converter from signed fixed-point (CORDIC datapath format) to IEEE-754 single precision.

---
 rtl/fixed_to_float_seq.sv | 178 +++++++++++++++++
 tb/tb_fixed_to_float_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float_seq.sv
// fixed_to_float_seq
//
// Multi-cycle converter from a signed two's-complement fixed-point value
// (the CORDIC datapath format) to an IEEE-754 single-precision float. It
// normalizes by shifting out one leading zero per cycle, so the latency
// depends on the magnitude of the operand.
//
// Parameters
//   XLEN       float width (32 is the only meaningful value)
//   FIX_W      fixed-point input width, 25..64
//   FRAC_BITS  number of fractional bits in in_fix, 0..FIX_W-1
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          synchronous active-high reset
//   in_valid     in_fix holds an operand
//   in_ready     converter is idle and will accept on this edge
//   in_fix       signed fixed-point operand
//   out_valid    out_float / out_inexact hold a result
//   out_ready    consumer takes the result on this edge
//   out_float    {sign, exp[7:0], man[22:0]}
//   out_inexact  nonzero bits were discarded while packing the mantissa
//
// Build option
//   FIX2FLT_ROUND_EN  defined: round to nearest, ties to even.
//                     undefined: truncate toward zero, no incrementer.

module fixed_to_float_seq #(
    parameter int XLEN      = 32,
    parameter int FIX_W     = 32,
    parameter int FRAC_BITS = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FIX_W-1:0] in_fix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_float,
    output logic             out_inexact
);

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        NORM,
        PACK,
        DONE
    } state_t;

    // Exponent of a value whose leading one sits in the MSB of mag, before
    // subtracting the shift count. Legal parameters keep the result in 1..254.
    localparam logic [7:0] EXP_TOP = 8'(127 + FIX_W - 1 - FRAC_BITS);

    // Everything below the guard bit feeds the sticky bit. For FIX_W=25 there
    // are no such bits, and the mask collapses to zero.
    localparam logic [FIX_W-1:0] STICKY_MASK = {FIX_W{1'b1}} >> 25;

    state_t           state;
    state_t           state_next;
    logic [FIX_W-1:0] mag;
    logic             sign;
    logic [6:0]       cnt;

    logic             accept;
    logic [FIX_W-1:0] mag_abs;
    logic [22:0]      man_trunc;
    logic             guard;
    logic             sticky;
    logic [7:0]       exp_base;
    logic [7:0]       pack_exp;
    logic [22:0]      pack_man;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // State register. Reset wins over everything, including an in-flight
    // conversion, so an aborted result can never reach DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. NORM loops until the leading one reaches the MSB;
    // a zero operand skips normalization entirely since it has no leading one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = ABS;
            ABS:  state_next = (mag_abs == '0) ? DONE : NORM;
            NORM: if (mag[FIX_W-1]) state_next = PACK;
            PACK: state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Magnitude of the registered operand. The most negative input maps to
    // 2^(FIX_W-1), which still fits as an unsigned FIX_W-bit value.
    always_comb begin
        mag_abs = mag;
        if (mag[FIX_W-1]) begin
            mag_abs = ~mag + {{(FIX_W-1){1'b0}}, 1'b1};
        end
    end

    // Field extraction and rounding for the PACK state. The hidden one is
    // mag[FIX_W-1]; the 23 bits below it form the mantissa. A rounding carry
    // out of the mantissa leaves it all-zero and bumps the exponent by one.
    always_comb begin
        man_trunc = mag[FIX_W-2 -: 23];
        guard     = mag[FIX_W-25];
        sticky    = |(mag & STICKY_MASK);
        exp_base  = EXP_TOP - {1'b0, cnt};
`ifdef FIX2FLT_ROUND_EN
        begin
            logic        round_up;
            logic [23:0] man_sum;
            round_up = guard & (sticky | man_trunc[0]);
            man_sum  = {1'b0, man_trunc} + {23'b0, round_up};
            pack_man = man_sum[22:0];
            pack_exp = exp_base + {7'b0, man_sum[23]};
        end
`else
        pack_man = man_trunc;
        pack_exp = exp_base;
`endif
    end

    // Datapath. The operand is captured straight into mag on accept, turned
    // into sign/magnitude in ABS, shifted in NORM and packed in PACK. The
    // output registers only change in ABS (zero case) and PACK, so they stay
    // stable for as long as the consumer holds off out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag         <= '0;
            sign        <= 1'b0;
            cnt         <= '0;
            out_float   <= '0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag <= in_fix;
                    end
                end
                ABS: begin
                    sign <= mag[FIX_W-1];
                    mag  <= mag_abs;
                    cnt  <= '0;
                    if (mag_abs == '0) begin
                        out_float   <= '0;
                        out_inexact <= 1'b0;
                    end
                end
                NORM: begin
                    if (!mag[FIX_W-1]) begin
                        mag <= mag << 1;
                        cnt <= cnt + 7'd1;
                    end
                end
                PACK: begin
                    out_float   <= {sign, pack_exp, pack_man};
                    out_inexact <= guard | sticky;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float_seq.sv
// tb_fixed_to_float_seq
//
// Directed testbench for fixed_to_float_seq at FIX_W=32, FRAC_BITS=30.
// Each vector carries a hand-computed float, inexact flag and latency.
// Expectations that depend on the rounding mode follow FIX2FLT_ROUND_EN.

module tb_fixed_to_float_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_fix;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_inexact;

    int n_checks = 0;
    int n_fail   = 0;

    fixed_to_float_seq #(
        .XLEN(32),
        .FIX_W(32),
        .FRAC_BITS(30)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_fix(in_fix),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_float(out_float),
        .out_inexact(out_inexact)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something upstream stops advancing time sensibly.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, required end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and on mismatch counts the failure and
    // reports the tag with observed and expected values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one operand, waits for it to be accepted, then counts rising
    // edges (the accept edge is edge 1) until out_valid shows up. out_ready
    // is left low, so the result is held for the caller to inspect.
    task automatic applyStimulus(input logic [31:0] fix, output int lat);
        int k;
        @(negedge clk);
        in_fix   = fix;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_fix   = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Completes the output handshake and checks the converter is idle again.
    task automatic finishHandshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, " valid_drop"}, {31'b0, out_valid}, 32'd0);
        checkOutput({tag, " ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    // Full directed vector: convert, check result, flag and latency, release.
    task automatic runVector(input string tag, input logic [31:0] fix,
                             input logic [31:0] exp_float, input logic exp_inexact,
                             input int exp_lat);
        int lat;
        applyStimulus(fix, lat);
        checkOutput({tag, " float"},   out_float, exp_float);
        checkOutput({tag, " inexact"}, {31'b0, out_inexact}, {31'b0, exp_inexact});
        checkOutput({tag, " latency"}, lat, exp_lat);
        finishHandshake(tag);
    endtask

    initial begin
        logic [31:0] held;
        int          lat;
        int          glitches;

        $display("[TB] fixed_to_float_seq directed test");
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_fix    = '0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst in_ready",    {31'b0, in_ready},    32'd0);
        checkOutput("rst out_valid",   {31'b0, out_valid},   32'd0);
        checkOutput("rst out_float",   out_float,            32'd0);
        checkOutput("rst out_inexact", {31'b0, out_inexact}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_rst in_ready", {31'b0, in_ready}, 32'd1);

        // Main vectors.
        runVector("plus_one",  32'h4000_0000, 32'h3F80_0000, 1'b0, 5);
        runVector("minus_two", 32'h8000_0000, 32'hC000_0000, 1'b0, 4);
        runVector("minus_one", 32'hC000_0000, 32'hBF80_0000, 1'b0, 5);
        runVector("zero",      32'h0000_0000, 32'h0000_0000, 1'b0, 2);
        runVector("lsb",       32'h0000_0001, 32'h3080_0000, 1'b0, 35);
        runVector("one_half",  32'h6000_0000, 32'h3FC0_0000, 1'b0, 5);
        // Exact tie with an even mantissa: stays put in either mode.
        runVector("tie_even",  32'h4000_0040, 32'h3F80_0000, 1'b1, 5);
`ifdef FIX2FLT_ROUND_EN
        runVector("max_pos",   32'h7FFF_FFFF, 32'h4000_0000, 1'b1, 5);
        runVector("tie_odd",   32'h4000_00C0, 32'h3F80_0002, 1'b1, 5);
`else
        runVector("max_pos",   32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b1, 5);
        runVector("tie_odd",   32'h4000_00C0, 32'h3F80_0001, 1'b1, 5);
`endif

        // Back-pressure: hold out_ready low for three cycles while a new
        // operand is offered; it must be ignored until the handshake.
        applyStimulus(32'h6000_0000, lat);
        held = out_float;
        checkOutput("bp first", held, 32'h3FC0_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_fix   = 32'h4000_0000;
            #1;
            checkOutput("bp stable",   out_float, 32'h3FC0_0000);
            checkOutput("bp valid",    {31'b0, out_valid}, 32'd1);
            checkOutput("bp in_ready", {31'b0, in_ready},  32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp handshake valid", {31'b0, out_valid}, 32'd0);
        checkOutput("bp idle ready",      {31'b0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp next accepted", {31'b0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("bp next float",   out_float, 32'h3F80_0000);
        checkOutput("bp next latency", lat, 32'd5);
        finishHandshake("bp next");

        // Reset in the middle of normalizing 0x00000001 aborts it.
        @(negedge clk);
        in_fix   = 32'h0000_0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort rst in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abort valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort in_ready", {31'b0, in_ready}, 32'd1);
        glitches = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) glitches++;
        end
        checkOutput("abort no result", glitches, 32'd0);
        runVector("after_abort", 32'h4000_0000, 32'h3F80_0000, 1'b0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
